// File: rtl/streamer_checker_pkg.sv
// streamer_checker_pkg
// Shared types, widths and helper functions for the rx_streamer sequence checker.
// Optional feature macro used by the checker: STREAMER_SEQ_CHECKER_LAT_STATS_EN.
package streamer_checker_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } t_checker_state;

   localparam logic [7:0] c_LFSR_TAPS = 8'hB8;

   localparam int c_WORDS_W = 32;
   localparam int c_ERR_W   = 32;
   localparam int c_LOST_W  = 16;
   localparam int c_LAT_W   = 28;

   // Latency minimum starts at the largest representable value so any sample replaces it.
   localparam logic [c_LAT_W-1:0] c_LAT_MIN_INIT = 28'hFFF_FFFF;

   // One step of the 8-bit Galois LFSR (right-shifting, feedback from bit 0).
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      logic [7:0] shifted;
      shifted = {1'b0, v[7:1]};
      if (v[0]) begin
         return shifted ^ c_LFSR_TAPS;
      end else begin
         return shifted;
      end
   endfunction

   // Saturating increment for 32-bit statistics.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) begin
         return v;
      end else begin
         return v + 32'd1;
      end
   endfunction

   // Saturating increment for 16-bit statistics.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

endpackage

// File: rtl/streamer_dreq_lfsr.sv
// streamer_dreq_lfsr
// Pseudo-random data-request generator: an 8-bit Galois LFSR compared against a
// threshold; the request output is registered (one cycle behind the LFSR value).
module streamer_dreq_lfsr
   import streamer_checker_pkg::*;
#(
   parameter logic [7:0] g_lfsr_seed = 8'hA5
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       enable_i,
   input  logic [7:0] thr_i,
   output logic       dreq_o
);

   logic [7:0] lfsr_q;
   logic       dreq_q;

   // LFSR advances every cycle out of reset; dreq is the registered threshold compare.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         lfsr_q <= g_lfsr_seed;
         dreq_q <= 1'b0;
      end else begin
         lfsr_q <= lfsr_next(lfsr_q);
         dreq_q <= enable_i && ((thr_i == 8'hFF) || (lfsr_q < thr_i));
      end
   end

   assign dreq_o = dreq_q;

endmodule

// File: rtl/streamer_seq_checker.sv
// streamer_seq_checker
// Sink for the rx_streamer user interface: requests data with a pseudo-random duty,
// checks received records form an incrementing sequence and keeps saturating stats.
// Optional latency min/max tracking is enabled by defining STREAMER_SEQ_CHECKER_LAT_STATS_EN.
module streamer_seq_checker
   import streamer_checker_pkg::*;
#(
   parameter int         g_data_width = 64,
   parameter logic [7:0] g_lfsr_seed  = 8'hA5
) (
   input  logic                    clk_sys_i,
   input  logic                    rst_n_i,
   input  logic [g_data_width-1:0] rx_data_i,
   input  logic                    rx_valid_i,
   output logic                    rx_dreq_o,
   input  logic                    rx_lost_i,
   input  logic [27:0]             rx_latency_i,
   input  logic                    rx_latency_valid_i,
   input  logic                    enable_i,
   input  logic                    clear_i,
   input  logic [7:0]              cfg_dreq_thr_i,
   output logic                    locked_o,
   output logic                    err_o,
   output logic [31:0]             stat_words_o,
   output logic [31:0]             stat_errors_o,
   output logic [15:0]             stat_lost_o,
   output logic [27:0]             lat_min_o,
   output logic [27:0]             lat_max_o
);

   localparam logic [g_data_width-1:0] c_DATA_ONE = {{(g_data_width-1){1'b0}}, 1'b1};

   t_checker_state            state_q;
   logic [g_data_width-1:0]   expected_q;
   logic [c_WORDS_W-1:0]      words_q;
   logic [c_ERR_W-1:0]        errors_q;
   logic [c_LOST_W-1:0]       lost_q;
   logic                      err_q;
   logic                      locked_q;

   streamer_dreq_lfsr #(
      .g_lfsr_seed (g_lfsr_seed)
   ) u_dreq (
      .clk_i    (clk_sys_i),
      .rst_n_i  (rst_n_i),
      .enable_i (enable_i),
      .thr_i    (cfg_dreq_thr_i),
      .dreq_o   (rx_dreq_o)
   );

   // Sequence-check FSM with statistics; clear beats any same-cycle valid/lost event,
   // and locked_q is updated together with every state change so it mirrors LOCKED.
   always_ff @(posedge clk_sys_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         expected_q <= {g_data_width{1'b0}};
         words_q    <= 32'd0;
         errors_q   <= 32'd0;
         lost_q     <= 16'd0;
         err_q      <= 1'b0;
         locked_q   <= 1'b0;
      end else if (clear_i) begin
         words_q  <= 32'd0;
         errors_q <= 32'd0;
         lost_q   <= 16'd0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
         if (enable_i) begin
            state_q <= SYNC;
         end else begin
            state_q <= IDLE;
         end
      end else if (!enable_i) begin
         state_q  <= IDLE;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               state_q  <= SYNC;
               locked_q <= 1'b0;
            end
            SYNC: begin
               // First word after (re)sync defines the sequence; it is never an error.
               if (rx_valid_i) begin
                  expected_q <= rx_data_i + c_DATA_ONE;
                  words_q    <= sat_inc32(words_q);
                  state_q    <= LOCKED;
                  locked_q   <= 1'b1;
               end else begin
                  locked_q <= 1'b0;
               end
            end
            LOCKED: begin
               if (rx_lost_i) begin
                  // Data was lost upstream: count it, accept any coincident word
                  // unchecked and fall back to resynchronising.
                  lost_q <= sat_inc16(lost_q);
                  if (rx_valid_i) begin
                     words_q <= sat_inc32(words_q);
                  end
                  state_q  <= SYNC;
                  locked_q <= 1'b0;
               end else if (rx_valid_i) begin
                  words_q    <= sat_inc32(words_q);
                  // Follow the received value even after a mismatch so one
                  // glitch produces a single error, not a cascade.
                  expected_q <= rx_data_i + c_DATA_ONE;
                  if (rx_data_i != expected_q) begin
                     errors_q <= sat_inc32(errors_q);
                     err_q    <= 1'b1;
                  end
               end
            end
            default: begin
               state_q  <= IDLE;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign locked_o      = locked_q;
   assign err_o         = err_q;
   assign stat_words_o  = words_q;
   assign stat_errors_o = errors_q;
   assign stat_lost_o   = lost_q;

`ifdef STREAMER_SEQ_CHECKER_LAT_STATS_EN
   logic [c_LAT_W-1:0] lat_min_q;
   logic [c_LAT_W-1:0] lat_max_q;

   // Latency extremes, tracked on every latency strobe and restarted by clear.
   always_ff @(posedge clk_sys_i) begin
      if (!rst_n_i) begin
         lat_min_q <= c_LAT_MIN_INIT;
         lat_max_q <= 28'd0;
      end else if (clear_i) begin
         lat_min_q <= c_LAT_MIN_INIT;
         lat_max_q <= 28'd0;
      end else if (rx_latency_valid_i) begin
         if (rx_latency_i < lat_min_q) begin
            lat_min_q <= rx_latency_i;
         end
         if (rx_latency_i > lat_max_q) begin
            lat_max_q <= rx_latency_i;
         end
      end
   end

   assign lat_min_o = lat_min_q;
   assign lat_max_o = lat_max_q;
`else
   logic unused_lat_s;

   assign unused_lat_s = ^{rx_latency_i, rx_latency_valid_i};
   assign lat_min_o    = {c_LAT_W{1'b0}};
   assign lat_max_o    = {c_LAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_streamer_seq_checker.sv
// tb_streamer_seq_checker
// Directed plus randomized stimulus for streamer_seq_checker, checked against a
// rule-level reference model. Honours STREAMER_SEQ_CHECKER_LAT_STATS_EN if defined.
module tb_streamer_seq_checker;

   localparam int DW = 64;
   localparam int M_IDLE = 0;
   localparam int M_SYNC = 1;
   localparam int M_LOCKED = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] dat = '0;
   logic          vld = 1'b0;
   logic          dreq;
   logic          lst = 1'b0;
   logic [27:0]   lat = '0;
   logic          latv = 1'b0;
   logic          en = 1'b0;
   logic          clr = 1'b0;
   logic [7:0]    thr = 8'h00;
   logic          locked;
   logic          err;
   logic [31:0]   words;
   logic [31:0]   errs;
   logic [15:0]   lost;
   logic [27:0]   lat_min;
   logic [27:0]   lat_max;

   int checks = 0;
   int errors = 0;

   // reference model state
   int                m_mode;
   logic [DW-1:0]     m_exp;
   longint unsigned   m_words, m_errs, m_lost;
   bit                m_err;
   logic [27:0]       m_lmin, m_lmax;

   streamer_seq_checker #(.g_data_width(DW), .g_lfsr_seed(8'hA5)) dut (
      .clk_sys_i          (clk),
      .rst_n_i            (rst_n),
      .rx_data_i          (dat),
      .rx_valid_i         (vld),
      .rx_dreq_o          (dreq),
      .rx_lost_i          (lst),
      .rx_latency_i       (lat),
      .rx_latency_valid_i (latv),
      .enable_i           (en),
      .clear_i            (clr),
      .cfg_dreq_thr_i     (thr),
      .locked_o           (locked),
      .err_o              (err),
      .stat_words_o       (words),
      .stat_errors_o      (errs),
      .stat_lost_o        (lost),
      .lat_min_o          (lat_min),
      .lat_max_o          (lat_max)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned inc_sat(input longint unsigned v, input longint unsigned lim);
      return (v >= lim) ? lim : v + 64'd1;
   endfunction

   // Apply the spec rules for one clock edge using the inputs held across it.
   task automatic model_edge();
      m_err = 1'b0;
      if (!rst_n) begin
         m_mode = M_IDLE; m_exp = '0; m_words = 0; m_errs = 0; m_lost = 0;
         m_lmin = 28'hFFF_FFFF; m_lmax = 28'd0;
      end else begin
         if (clr) begin
            m_words = 0; m_errs = 0; m_lost = 0;
            m_mode = en ? M_SYNC : M_IDLE;
         end else if (!en) begin
            m_mode = M_IDLE;
         end else if (m_mode == M_IDLE) begin
            m_mode = M_SYNC;
         end else if (m_mode == M_SYNC) begin
            if (vld) begin
               m_exp = dat + 64'd1; m_words = inc_sat(m_words, 64'hFFFF_FFFF); m_mode = M_LOCKED;
            end
         end else begin
            if (lst) begin
               m_lost = inc_sat(m_lost, 64'hFFFF);
               if (vld) m_words = inc_sat(m_words, 64'hFFFF_FFFF);
               m_mode = M_SYNC;
            end else if (vld) begin
               m_words = inc_sat(m_words, 64'hFFFF_FFFF);
               if (dat != m_exp) begin
                  m_errs = inc_sat(m_errs, 64'hFFFF_FFFF); m_err = 1'b1;
               end
               m_exp = dat + 64'd1;
            end
         end
         if (clr) begin
            m_lmin = 28'hFFF_FFFF; m_lmax = 28'd0;
         end else if (latv) begin
            if (lat < m_lmin) m_lmin = lat;
            if (lat > m_lmax) m_lmax = lat;
         end
      end
   endtask

   // One clock: edge, settle, update model, compare all checker outputs.
   task automatic tick();
      @(posedge clk);
      #1;
      model_edge();
      check("err_o", 64'(err), 64'(m_err));
      check("locked_o", 64'(locked), 64'(m_mode == M_LOCKED));
      check("stat_words", 64'(words), m_words);
      check("stat_errors", 64'(errs), m_errs);
      check("stat_lost", 64'(lost), m_lost);
`ifdef STREAMER_SEQ_CHECKER_LAT_STATS_EN
      check("lat_min", 64'(lat_min), 64'(m_lmin));
      check("lat_max", 64'(lat_max), 64'(m_lmax));
`else
      check("lat_min_tied", 64'(lat_min), 64'd0);
      check("lat_max_tied", 64'(lat_max), 64'd0);
`endif
   endtask

   task automatic send(input logic [DW-1:0] d);
      vld = 1'b1; dat = d;
      tick();
      vld = 1'b0;
   endtask

   task automatic pulse_clear();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      int cnt;
      logic [DW-1:0] gen;

      // Reset state
      rst_n = 1'b0; en = 1'b0; thr = 8'hFF;
      tick(); tick();
      check("reset_dreq", 64'(dreq), 64'd0);
      check("reset_words", 64'(words), 64'd0);
      check("reset_locked", 64'(locked), 64'd0);
      rst_n = 1'b1;

      // Test 1: always-request, clean count 0..99
      en = 1'b1;
      tick();
      check("dreq_thr_ff", 64'(dreq), 64'd1);
      for (int i = 0; i < 100; i++) begin
         send(64'(i));
         check("dreq_const", 64'(dreq), 64'd1);
      end
      check("t1_words", 64'(words), 64'd100);
      check("t1_errors", 64'(errs), 64'd0);
      check("t1_locked", 64'(locked), 64'd1);

      // Test 2: gap in sequence -> one error, resync on received value
      pulse_clear();
      for (int i = 0; i < 10; i++) send(64'(i));
      send(64'd12);
      check("t2_err_pulse", 64'(err), 64'd1);
      send(64'd13);
      check("t2_err_clear", 64'(err), 64'd0);
      check("t2_words", 64'(words), 64'd12);
      check("t2_errors", 64'(errs), 64'd1);

      // Test 3: modulo wrap
      pulse_clear();
      send(64'hFFFF_FFFF_FFFF_FFFE);
      send(64'hFFFF_FFFF_FFFF_FFFF);
      send(64'd0);
      send(64'd1);
      check("t3_errors", 64'(errs), 64'd0);
      check("t3_words", 64'(words), 64'd4);

      // Test 4: loss event forces resync
      pulse_clear();
      for (int i = 0; i <= 5; i++) send(64'(i));
      lst = 1'b1; tick(); lst = 1'b0;
      check("t4_unlocked", 64'(locked), 64'd0);
      send(64'd50);
      check("t4_relocked", 64'(locked), 64'd1);
      send(64'd51);
      check("t4_lost", 64'(lost), 64'd1);
      check("t4_errors", 64'(errs), 64'd0);

      // Clear wins over a same-cycle valid and lost
      vld = 1'b1; dat = 64'd999; lst = 1'b1; clr = 1'b1;
      tick();
      vld = 1'b0; lst = 1'b0; clr = 1'b0;
      check("clr_prio_words", 64'(words), 64'd0);
      check("clr_prio_lost", 64'(lost), 64'd0);

      // Test 5: dreq duty for several thresholds and when disabled
      thr = 8'h40;
      tick();
      cnt = 0;
      for (int i = 0; i < 4096; i++) begin
         tick();
         cnt += int'(dreq);
      end
      check("duty_40_ge20pct", 64'(cnt >= 819), 64'd1);
      check("duty_40_le30pct", 64'(cnt <= 1229), 64'd1);
      thr = 8'h00;
      tick();
      cnt = 0;
      for (int i = 0; i < 512; i++) begin
         tick();
         cnt += int'(dreq);
      end
      check("duty_thr0", 64'(cnt), 64'd0);
      thr = 8'hFF; en = 1'b0;
      tick();
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
         tick();
         cnt += int'(dreq);
      end
      check("dreq_disabled", 64'(cnt), 64'd0);
      en = 1'b1;
      tick();

      // Reset mid-stream, first post-reset word resyncs
      for (int i = 0; i < 4; i++) send(64'(200 + i));
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("midrst_words", 64'(words), 64'd0);
      check("midrst_dreq", 64'(dreq), 64'd0);
      tick();
      send(64'd77);
      send(64'd78);
      check("midrst_errors", 64'(errs), 64'd0);

      // Test 6: latency statistics (tied to zero when the feature is off)
      latv = 1'b1;
      lat = 28'd300; tick();
      lat = 28'd120; tick();
      lat = 28'd900; tick();
      latv = 1'b0;
`ifdef STREAMER_SEQ_CHECKER_LAT_STATS_EN
      check("t6_min", 64'(lat_min), 64'd120);
      check("t6_max", 64'(lat_max), 64'd900);
      pulse_clear();
      check("t6_min_clr", 64'(lat_min), 64'hFFF_FFFF);
      check("t6_max_clr", 64'(lat_max), 64'd0);
`else
      pulse_clear();
`endif

      // Randomized traffic: gaps, skips, losses, clears, latency strobes
      gen = 64'($urandom);
      for (int i = 0; i < 800; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         clr = (r < 2);
         lst = (r >= 2 && r < 6);
         vld = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) gen = gen + 64'($urandom_range(2, 9));
         dat = gen;
         if (vld) gen = gen + 64'd1;
         latv = 1'($urandom_range(0, 3) == 0);
         lat = 28'($urandom);
         thr = 8'($urandom);
         tick();
      end
      clr = 1'b0; lst = 1'b0; vld = 1'b0; latv = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
